// File: rtl/i2s_rx.sv
// I2S slave receiver: synchronizes bck/lrck/data into clk, deserializes
// stereo frames and holds the last one behind a valid/ack register.
module i2s_rx #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  i2s_bck,
  input  logic                  i2s_lrck,
  input  logic                  i2s_data,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  sample_valid,
  input  logic                  sample_ack,
  output logic                  overrun,
  input  logic                  overrun_clear
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MSB =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  bck_sync_q, bck_sync_d;
  logic [SYNC_STAGES-1:0]  lrck_sync_q, lrck_sync_d;
  logic [SYNC_STAGES-1:0]  data_sync_q, data_sync_d;
  logic                    bck_prev_q, bck_prev_d;
  logic                    lrck_prev_q, lrck_prev_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   lword_q, lword_d;
  logic [DATA_WIDTH-1:0]   rword_q, rword_d;
  logic [DATA_WIDTH-1:0]   left_q, left_d;
  logic [DATA_WIDTH-1:0]   right_q, right_d;
  logic                    commit_q, commit_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;

  logic                    bck_s, lrck_s, data_s;
  logic                    bck_rise, lr_flip, commit;
  logic [DATA_WIDTH-1:0]   shift_ins;
  logic [CW-1:0]           cnt_ins;

  assign bck_s    = bck_sync_q[SYNC_STAGES-1];
  assign lrck_s   = lrck_sync_q[SYNC_STAGES-1];
  assign data_s   = data_sync_q[SYNC_STAGES-1];
  assign bck_rise = bck_s & ~bck_prev_q;
  assign lr_flip  = lrck_s ^ lrck_prev_q;
  assign commit   = commit_q & enable;

  // Bits land MSB-first; the mask runs out once DATA_WIDTH bits are kept.
  assign shift_ins = data_s ? (shift_q | (MSB >> cnt_q)) : shift_q;
  assign cnt_ins   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    bck_sync_d  = {bck_sync_q[SYNC_STAGES-2:0], i2s_bck};
    lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], i2s_lrck};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], i2s_data};
    bck_prev_d  = bck_s;
    lrck_prev_d = bck_rise ? lrck_s : lrck_prev_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    lword_d     = lword_q;
    rword_d     = rword_q;
    commit_d    = 1'b0;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;

    if (!enable) begin
      state_d = ALIGN;
      cnt_d   = '0;
      shift_d = '0;
    end else if (bck_rise) begin
      unique case (state_q)
        ALIGN: begin
          if (lrck_prev_q && !lrck_s) begin
            state_d = LEFT;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        LEFT: begin
          if (lr_flip) begin
            lword_d = shift_ins;
            cnt_d   = '0;
            shift_d = '0;
            state_d = RIGHT;
          end else begin
            cnt_d   = cnt_ins;
            shift_d = shift_ins;
          end
        end
        RIGHT: begin
          if (lr_flip) begin
            rword_d  = shift_ins;
            commit_d = 1'b1;
            cnt_d    = '0;
            shift_d  = '0;
            state_d  = LEFT;
          end else begin
            cnt_d   = cnt_ins;
            shift_d = shift_ins;
          end
        end
        default: state_d = ALIGN;
      endcase
    end

    if (commit) begin
      left_d  = lword_q;
      right_d = rword_q;
      valid_d = 1'b1;
    end else if (sample_ack) begin
      valid_d = 1'b0;
    end

    // A fresh overrun outranks a simultaneous clear.
    if (commit && valid_q && !sample_ack) begin
      overrun_d = 1'b1;
    end else if (overrun_clear) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ALIGN;
      bck_sync_q  <= '0;
      lrck_sync_q <= '0;
      data_sync_q <= '0;
      bck_prev_q  <= 1'b0;
      lrck_prev_q <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      lword_q     <= '0;
      rword_q     <= '0;
      left_q      <= '0;
      right_q     <= '0;
      commit_q    <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bck_sync_q  <= bck_sync_d;
      lrck_sync_q <= lrck_sync_d;
      data_sync_q <= data_sync_d;
      bck_prev_q  <= bck_prev_d;
      lrck_prev_q <= lrck_prev_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      lword_q     <= lword_d;
      rword_q     <= rword_d;
      left_q      <= left_d;
      right_q     <= right_d;
      commit_q    <= commit_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign left_data    = left_q;
  assign right_data   = right_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: random and directed I2S frames, scoreboard monitor
// with auto-ack, plus directed overrun, latency, reset and enable cases.
module tb_i2s_rx;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic i2s_bck = 1'b0;
  logic i2s_lrck = 1'b0;
  logic i2s_data = 1'b0;
  logic [DW-1:0] left_data, right_data;
  logic sample_valid, sample_ack, overrun;
  logic overrun_clear = 1'b0;
  logic mon_ack = 1'b0;
  logic dir_ack = 1'b0;
  logic auto_ack = 1'b0;
  logic pend = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [2*DW-1:0] sb_q[$];

  typedef struct {
    int nl;
    logic [63:0] vl;
    int nr;
    logic [63:0] vr;
  } frame_t;

  assign sample_ack = mon_ack | dir_ack;
  always #5 clk = ~clk;

  i2s_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck), .i2s_data(i2s_data),
    .left_data(left_data), .right_data(right_data),
    .sample_valid(sample_valid), .sample_ack(sample_ack),
    .overrun(overrun), .overrun_clear(overrun_clear)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Word = first min(n,DW) bits sent, MSB-aligned, zero-filled.
  function automatic logic [DW-1:0] exp_word(int n, logic [63:0] v);
    logic [63:0] t;
    if (n >= DW) t = v >> (n - DW);
    else t = v << (DW - n);
    return t[DW-1:0];
  endfunction

  function automatic logic [63:0] rand_bits(int n);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return (n >= 64) ? r : (r & ((64'd1 << n) - 64'd1));
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    f.nl = $urandom_range(40, 1);
    f.vl = rand_bits(f.nl);
    f.nr = $urandom_range(40, 1);
    f.vr = rand_bits(f.nr);
    return f;
  endfunction

  // Data pin lags the slot bit by one bck (I2S one-bit delay).
  task automatic half_low(input logic lr, input logic b);
    i2s_bck = 1'b0;
    i2s_lrck = lr;
    i2s_data = pend;
    pend = b;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bit(input logic lr, input logic b);
    half_low(lr, b);
    i2s_bck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_slot(input logic lr, input int n,
                           input logic [63:0] v, input int first);
    for (int i = first; i < n; i++) send_bit(lr, v[n-1-i]);
  endtask

  task automatic send_frame(input frame_t f);
    send_slot(1'b0, f.nl, f.vl, 0);
    send_slot(1'b1, f.nr, f.vr, 0);
  endtask

  // Closing edge of a right word; ack driven in the commit cycle if asked.
  task automatic close_edge(input logic b, input logic ack,
                            output logic v_before);
    half_low(1'b0, b);
    i2s_bck = 1'b1;
    repeat (3) @(negedge clk);
    v_before = sample_valid;
    dir_ack = ack;
    @(negedge clk);
    dir_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    dir_ack = 1'b1;
    @(negedge clk);
    dir_ack = 1'b0;
  endtask

  task automatic check_frame(input string name, input frame_t f);
    check({name, "_left"}, left_data, exp_word(f.nl, f.vl));
    check({name, "_right"}, right_data, exp_word(f.nr, f.vr));
  endtask

  task automatic check_zero(input string name);
    check({name, "_left"}, left_data, 0);
    check({name, "_right"}, right_data, 0);
    check({name, "_valid"}, sample_valid, 0);
    check({name, "_overrun"}, overrun, 0);
  endtask

  initial begin : monitor
    logic [2*DW-1:0] e;
    forever begin
      @(negedge clk);
      if (auto_ack && sample_valid && !mon_ack) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %h/%h expected none",
                   left_data, right_data);
        end else begin
          e = sb_q.pop_front();
          check("mon_left", left_data, e[2*DW-1:DW]);
          check("mon_right", right_data, e[DW-1:0]);
        end
        mon_ack = 1'b1;
      end else begin
        mon_ack = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    frame_t f, y1, y2, z1, z2, z3, w, v;
    logic vb;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    enable = 1'b1;

    auto_ack = 1'b1;
    send_slot(1'b1, 8, rand_bits(8), 0);
    for (int k = 0; k < 22; k++) begin
      if (k == 0) begin
        f.nl = 32; f.vl = 64'h12345600;
        f.nr = 32; f.vr = 64'hABCDEF00;
      end else if (k == 1) begin
        f.nl = 16; f.vl = 64'h8001;
        f.nr = 16; f.vr = 64'h7FFF;
      end else begin
        f = rand_frame();
      end
      sb_q.push_back({exp_word(f.nl, f.vl), exp_word(f.nr, f.vr)});
      send_frame(f);
    end
    send_slot(1'b0, 3, rand_bits(3), 0);
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
    check("auto_overrun", overrun, 0);
    check("auto_valid", sample_valid, 0);
    auto_ack = 1'b0;
    @(negedge clk);

    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    send_slot(1'b1, 8, rand_bits(8), 0);
    y1 = rand_frame();
    y2 = rand_frame();
    send_frame(y1);
    close_edge(y2.vl[y2.nl-1], 1'b0, vb);
    check("latency_pre", vb, 0);
    check("latency_valid", sample_valid, 1);
    check_frame("y1", y1);
    send_slot(1'b0, y2.nl, y2.vl, 1);
    send_slot(1'b1, y2.nr, y2.vr, 0);
    z1 = rand_frame();
    close_edge(z1.vl[z1.nl-1], 1'b1, vb);
    check("ackcommit_valid", sample_valid, 1);
    check("ackcommit_overrun", overrun, 0);
    check_frame("y2", y2);

    send_slot(1'b0, z1.nl, z1.vl, 1);
    pulse_ack();
    check("ack_clears_valid", sample_valid, 0);
    send_slot(1'b1, z1.nr, z1.vr, 0);
    z2 = rand_frame();
    z3 = rand_frame();
    send_slot(1'b0, z2.nl, z2.vl, 0);
    check("z1_valid", sample_valid, 1);
    check("z1_overrun", overrun, 0);
    check_frame("z1", z1);
    send_slot(1'b1, z2.nr, z2.vr, 0);
    send_slot(1'b0, z3.nl, z3.vl, 0);
    check("z2_overrun", overrun, 1);
    check_frame("z2", z2);
    send_slot(1'b1, z3.nr, z3.vr, 0);
    close_edge(1'b0, 1'b0, vb);
    check("z3_overrun", overrun, 1);
    check_frame("z3", z3);
    overrun_clear = 1'b1;
    @(negedge clk);
    overrun_clear = 1'b0;
    check("ovclr_overrun", overrun, 0);
    check("ovclr_valid", sample_valid, 1);

    send_slot(1'b0, 3, rand_bits(3), 0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    send_slot(1'b0, 4, rand_bits(4), 0);
    send_slot(1'b1, 5, rand_bits(5), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_slot(1'b1, 6, rand_bits(6), 0);
    w = rand_frame();
    send_frame(w);
    check("no_partial_commit", sample_valid, 0);
    close_edge($urandom_range(1, 0), 1'b0, vb);
    check("w_valid", sample_valid, 1);
    check_frame("w", w);

    send_slot(1'b0, 3, rand_bits(3), 0);
    enable = 1'b0;
    send_slot(1'b0, 2, rand_bits(2), 0);
    check("dis_valid", sample_valid, 1);
    check_frame("dis_hold", w);
    enable = 1'b1;
    send_slot(1'b0, 4, rand_bits(4), 0);
    send_slot(1'b1, 10, rand_bits(10), 0);
    v = rand_frame();
    send_slot(1'b0, v.nl, v.vl, 0);
    check_frame("realign_hold", w);
    pulse_ack();
    check("realign_ack", sample_valid, 0);
    send_slot(1'b1, v.nr, v.vr, 0);
    close_edge($urandom_range(1, 0), 1'b0, vb);
    check("v_valid", sample_valid, 1);
    check("v_overrun", overrun, 0);
    check_frame("v", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S slave receiver for external line-in or ADC audio: the receive-side counterpart of the audio DAC output path.
- Samples externally driven i2s_bck, i2s_lrck and i2s_data in the system clock domain, then deserializes each stereo frame into left and right signed PCM words.
- Presents each completed frame through a one-deep output register with a valid/ack handshake and a sticky overrun flag, for consumption by the audio mixer or a capture FIFO.

Parameters:
DATA_WIDTH, 24, width of left_data/right_data; received words are MSB-aligned to this width.
SYNC_STAGES, 2, number of synchronizer flops on each I2S input (minimum 2).

Ports:
clk  input  1  system clock; must be at least 4x the i2s_bck frequency
rst  input  1  synchronous reset, active-high
enable  input  1  receiver enable; when 0, receiver is held idle
i2s_bck  input  1  external bit clock
i2s_lrck  input  1  external word select; 0 = left, 1 = right
i2s_data  input  1  external serial data, MSB first
left_data  output  DATA_WIDTH  last completed left word, signed
right_data  output  DATA_WIDTH  last completed right word, signed
sample_valid  output  1  a completed frame is held in left_data/right_data
sample_ack  input  1  consumer accepts the held frame
overrun  output  1  sticky flag: a frame was overwritten before it was acked
overrun_clear  input  1  clears overrun

Behaviour:
- Reset (rst=1 on a rising clk): left_data=0, right_data=0, sample_valid=0, overrun=0. FSM goes to ALIGN; the shift register, bit counter and synchronizers are cleared. Reset mid-word discards the partial frame.
- Input conditioning: each I2S input passes through SYNC_STAGES flops. A bck rising edge is detected when the previous synced bck=0 and the current synced bck=1. All capture happens in the clk cycle of detection, using the synced data and lrck values.
- Framing follows I2S one-bit delay:
  - Let lrck_prev be the lrck value captured at the previous bck rising edge.
  - At an edge where lrck != lrck_prev, the data bit captured at that edge is the final (LSB) bit of the word for channel lrck_prev.
  - The next edge carries the MSB of the new channel.
- FSM states: ALIGN, LEFT, RIGHT.
  - ALIGN: shift nothing. Leave on a bck edge where lrck_prev=1 and lrck=0, going to LEFT with the bit counter cleared. The bit captured at that transition edge is discarded.
  - LEFT: shift in bits. At the edge where lrck goes 0->1, include that edge's bit, latch the left word internally, clear the counter and go to RIGHT.
  - RIGHT: shift in bits. At the edge where lrck goes 1->0, include that edge's bit, then commit the frame (see below) and go to LEFT.
  - enable=0: forces ALIGN and clears the counter and shift register. Outputs, sample_valid and overrun hold their values.
- Word assembly:
  - The bit counter saturates at DATA_WIDTH. Only the first DATA_WIDTH bits of a word are kept; extra bits are ignored.
  - A word with n<DATA_WIDTH bits is left-shifted by DATA_WIDTH-n, with LSBs zero-filled.
  - A word with n=0 bits is not possible; lrck toggling on consecutive edges yields a 1-bit word.
- Commit, in the clk cycle after the detecting edge:
  - left_data and right_data are loaded together and sample_valid=1.
  - If sample_valid was 1 and sample_ack=0 in the commit cycle, overrun is set to 1 and the data is still overwritten with the newer frame.
  - If sample_ack=1 in the same cycle as a commit, the new frame loads, sample_valid stays 1, and overrun is unchanged.
  - sample_ack with no commit clears sample_valid next cycle. sample_ack while sample_valid=0 is ignored.
- Latency: sample_valid rises SYNC_STAGES+2 clk cycles after the pin-level bck rising edge that closes the right word.
- overrun_clear clears overrun next cycle. If overrun_clear coincides with a new overrun event, the set wins.
- Data is never shifted during ALIGN, so a mid-frame start (after reset or enable) never produces a partial frame.

Test Plan:
- 32 bck per channel, left=0x123456 and right=0xABCDEF, each sent as 24 bits followed by 8 zero bits; ack each frame -> left_data=0x123456, right_data=0xABCDEF, sample_valid pulses once per frame, overrun=0.
- 16 bck per channel, left=0x8001, right=0x7FFF -> left_data=0x800100, right_data=0x7FFF00.
- Three frames with sample_ack held 0 -> overrun=1 after frame 2, data holds frame 3; then overrun_clear -> overrun=0, sample_valid remains 1.
- sample_ack asserted exactly in a commit cycle -> new frame loaded, sample_valid stays 1, overrun=0.
- rst released while lrck=1 midway through a right word -> no commit until the next full left+right frame; first data matches that frame exactly.
- Assert rst mid-left-word after one valid frame -> all outputs 0 next cycle, FSM back in ALIGN. Separately, drop enable mid-word -> outputs hold, and the next commit needs a fresh 1->0 lrck alignment.
